// File: rtl/hpdcache_pkg.sv
// Shared HPDcache memory-interface types.
//   req_portid_t        : requester port id carried with each L1.5 response
//   hpdcache_mem_resp_t : memory response payload (data, transaction id, error)
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH   = 32;
  localparam int unsigned HPDCACHE_MEM_TID_WIDTH    = 4;
  localparam int unsigned HPDCACHE_REQ_PORTID_WIDTH = 3;

  typedef logic [HPDCACHE_REQ_PORTID_WIDTH-1:0] req_portid_t;

  typedef struct packed {
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_resp_r_data;
    logic [HPDCACHE_MEM_TID_WIDTH-1:0]  mem_resp_r_id;
    logic                               mem_resp_r_error;
  } hpdcache_mem_resp_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO with one cycle of write-to-read latency.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   w_i / wok_o   : push request / FIFO not full (push = w_i & wok_o)
//   wdata_i       : push data
//   r_i / rok_o   : pop request / FIFO not empty (pop = r_i & rok_o)
//   rdata_o       : head entry, valid while rok_o
module hpdcache_fifo_reg #(
  parameter int unsigned DEPTH       = 2,
  parameter type         fifo_data_t = logic
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       w_i,
  output logic       wok_o,
  input  fifo_data_t wdata_i,
  input  logic       r_i,
  output logic       rok_o,
  output fifo_data_t rdata_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fifo_data_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop;

  assign wok_o   = (cnt_q != CNT_W'(DEPTH));
  assign rok_o   = (cnt_q != '0);
  assign push    = w_i & wok_o;
  assign pop     = r_i & rok_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointers and occupancy; pointers wrap at DEPTH-1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hpdcache_l15_resp_demux.sv
// Routes L1.5 responses to requester ports by port id, through a 2-entry FIFO,
// and tracks per-port outstanding requests to gate new ones.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   mem_resp_*_i/_o  : upstream response (valid/ready/pid/payload)
//   mem_resp_valid_o : per-port response valid, mem_resp_ready_i per-port ready
//   mem_resp_o       : head payload broadcast to all ports
//   mem_req_sent_i   : per-port pulse when a request was accepted downstream
//   mem_req_allow_o  : per-port permission to issue another request
//   err_pid_o        : sticky error (bad pid, unexpected response, counter overflow)
module hpdcache_l15_resp_demux #(
  parameter int unsigned N                   = 1,
  parameter int unsigned MAX_OUTSTANDING     = 4,
  parameter type         hpdcache_mem_resp_t = logic,
  parameter type         req_portid_t        = logic
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          mem_resp_valid_i,
  output logic                          mem_resp_ready_o,
  input  req_portid_t                   mem_resp_pid_i,
  input  hpdcache_mem_resp_t            mem_resp_i,
  output logic               [N-1:0]    mem_resp_valid_o,
  input  logic               [N-1:0]    mem_resp_ready_i,
  output hpdcache_mem_resp_t [N-1:0]    mem_resp_o,
  input  logic               [N-1:0]    mem_req_sent_i,
  output logic               [N-1:0]    mem_req_allow_o,
  output logic                          err_pid_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    req_portid_t        pid;
    hpdcache_mem_resp_t resp;
  } entry_t;

  entry_t                     fifo_wdata, fifo_rdata;
  logic                       fifo_rok, fifo_pop;
  logic [N-1:0][CNT_W-1:0]    outstanding_q;
  logic [N-1:0]               head_hit, port_busy, deliver, at_max;
  logic                       head_drop, sat_err, err_q;

  assign fifo_wdata.pid  = mem_resp_pid_i;
  assign fifo_wdata.resp = mem_resp_i;

  hpdcache_fifo_reg #(
    .DEPTH       (2),
    .fifo_data_t (entry_t)
  ) resp_fifo_i (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .w_i     (mem_resp_valid_i),
    .wok_o   (mem_resp_ready_o),
    .wdata_i (fifo_wdata),
    .r_i     (fifo_pop),
    .rok_o   (fifo_rok),
    .rdata_o (fifo_rdata)
  );

  // Head decode: a head is deliverable only to an in-range port expecting a response.
  always_comb begin
    head_hit  = '0;
    port_busy = '0;
    at_max    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      head_hit[i]        = fifo_rok && (32'(fifo_rdata.pid) == i);
      port_busy[i]       = (outstanding_q[i] != '0);
      at_max[i]          = (outstanding_q[i] == CNT_MAX);
      mem_req_allow_o[i] = (outstanding_q[i] < CNT_MAX);
      mem_resp_o[i]      = fifo_rdata.resp;
    end
  end

  assign mem_resp_valid_o = head_hit & port_busy;
  assign deliver          = mem_resp_valid_o & mem_resp_ready_i;
  // Illegal heads are discarded immediately so they never block the queue.
  assign head_drop        = fifo_rok & ~(|mem_resp_valid_o);
  assign fifo_pop         = head_drop | (|deliver);
  assign sat_err          = |(mem_req_sent_i & ~deliver & at_max);

  // Outstanding counters: a send and a delivery in the same cycle cancel out.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        case ({mem_req_sent_i[i], deliver[i]})
          2'b10:   if (!at_max[i]) outstanding_q[i] <= outstanding_q[i] + CNT_W'(1);
          2'b01:   outstanding_q[i] <= outstanding_q[i] - CNT_W'(1);
          default: outstanding_q[i] <= outstanding_q[i];
        endcase
      end
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (head_drop || sat_err) begin
      err_q <= 1'b1;
    end
  end

  assign err_pid_o = err_q;

endmodule

// File: tb/tb_hpdcache_l15_resp_demux.sv
module tb_hpdcache_l15_resp_demux;
  import hpdcache_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXO = 4;

  typedef struct packed {
    req_portid_t        pid;
    hpdcache_mem_resp_t resp;
  } exp_t;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic                       valid_i = 1'b0;
  logic                       ready_o;
  req_portid_t                pid_i = '0;
  hpdcache_mem_resp_t         resp_i = '0;
  logic [N-1:0]               valid_o;
  logic [N-1:0]               ready_i = '1;
  hpdcache_mem_resp_t [N-1:0] resp_o;
  logic [N-1:0]               sent_i = '0;
  logic [N-1:0]               allow_o;
  logic                       err_o;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   deliv_cnt = 0;

  hpdcache_l15_resp_demux #(
    .N                   (N),
    .MAX_OUTSTANDING     (MAXO),
    .hpdcache_mem_resp_t (hpdcache_mem_resp_t),
    .req_portid_t        (req_portid_t)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .mem_resp_valid_i (valid_i),
    .mem_resp_ready_o (ready_o),
    .mem_resp_pid_i   (pid_i),
    .mem_resp_i       (resp_i),
    .mem_resp_valid_o (valid_o),
    .mem_resp_ready_i (ready_i),
    .mem_resp_o       (resp_o),
    .mem_req_sent_i   (sent_i),
    .mem_req_allow_o  (allow_o),
    .err_pid_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: every handshake on a port pops the oldest expected response.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      total++;
      if (!$onehot0(valid_o)) begin
        bad++;
        $display("FAIL onehot_valid got=%b exp=at most one bit", valid_o);
      end
      for (int i = 0; i < N; i++) begin
        if (valid_o[i] && ready_i[i]) begin
          deliv_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_delivery got=port%0d exp=none", i);
          end else begin
            mon_e = exp_q.pop_front();
            if (int'(mon_e.pid) != i || resp_o[i] !== mon_e.resp) begin
              bad++;
              $display("FAIL delivery got=port%0d/%h exp=port%0d/%h", i, resp_o[i], mon_e.pid, mon_e.resp);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    sent_i  = '0;
    repeat (2) tick();
    exp_q.delete();
    ready_i = '1;
    rst_ni  = 1'b1;
  endtask

  task automatic pulse_sent(input logic [N-1:0] m);
    sent_i = m;
    tick();
    sent_i = '0;
  endtask

  // Drive one response until accepted; legal ones are expected at the ports.
  task automatic send_rsp(input req_portid_t pid, input logic legal, output int waits);
    hpdcache_mem_resp_t r;
    logic               acc;
    r.mem_resp_r_data  = $urandom;
    r.mem_resp_r_id    = 4'($urandom);
    r.mem_resp_r_error = 1'($urandom);
    valid_i = 1'b1;
    pid_i   = pid;
    resp_i  = r;
    waits   = 0;
    acc     = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #2;
      if (!acc) waits++;
    end
    valid_i = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout got=not accepted exp=accepted pid=%0d", pid);
    end else if (legal) begin
      exp_q.push_back('{pid: pid, resp: r});
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    total++;
    if (ready_o !== 1'b1 || valid_o !== '0 || allow_o !== 4'hF || err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=rdy%b v%b a%b e%b exp=rdy1 v0000 a1111 e0", ready_o, valid_o, allow_o, err_o);
    end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    pulse_sent(4'b0100);
    send_rsp(3'd2, 1'b1, w);
    total++;
    if (valid_o !== 4'b0100) begin
      bad++;
      $display("FAIL single_latency got=%b exp=0100", valid_o);
    end
    tick();
    total++;
    if (valid_o !== '0 || err_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_done got=v%b e%b q%0d exp=v0000 e0 q0", valid_o, err_o, exp_q.size());
    end
    // Counter must be back at zero, so a further pid 2 response is unexpected.
    send_rsp(3'd2, 1'b0, w);
    tick();
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL single_cnt_zero got=%b exp=1", err_o);
    end
  endtask

  task automatic test_back_to_back();
    int w0, w1, w2, base;
    do_reset();
    pulse_sent(4'b0011);
    pulse_sent(4'b0001);
    base = deliv_cnt;
    send_rsp(3'd0, 1'b1, w0);
    send_rsp(3'd1, 1'b1, w1);
    send_rsp(3'd0, 1'b1, w2);
    total++;
    if (w0 + w1 + w2 != 0) begin
      bad++;
      $display("FAIL b2b_ready got=%0d stalls exp=0", w0 + w1 + w2);
    end
    total++;
    if (deliv_cnt - base != 2) begin
      bad++;
      $display("FAIL b2b_throughput got=%0d exp=2", deliv_cnt - base);
    end
    tick();
    total++;
    if (deliv_cnt - base != 3 || exp_q.size() != 0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done got=d%0d q%0d e%b exp=d3 q0 e0", deliv_cnt - base, exp_q.size(), err_o);
    end
  endtask

  task automatic test_stall();
    int w, w3, base;
    do_reset();
    ready_i = 4'b1101;
    repeat (3) pulse_sent(4'b0010);
    base = deliv_cnt;
    fork
      begin
        send_rsp(3'd1, 1'b1, w);
        send_rsp(3'd1, 1'b1, w);
        send_rsp(3'd1, 1'b1, w3);
      end
      begin
        repeat (6) tick();
        total++;
        if (ready_o !== 1'b0 || valid_o !== 4'b0010 || exp_q.size() != 2 || deliv_cnt != base) begin
          bad++;
          $display("FAIL stall_full got=rdy%b v%b q%0d d%0d exp=rdy0 v0010 q2 d0", ready_o, valid_o, exp_q.size(), deliv_cnt - base);
        end
        ready_i = '1;
      end
    join
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0 || deliv_cnt - base != 3 || w3 == 0) begin
      bad++;
      $display("FAIL stall_drain got=q%0d d%0d w%0d exp=q0 d3 w>0", exp_q.size(), deliv_cnt - base, w3);
    end
  endtask

  task automatic test_illegal_pid();
    int w;
    do_reset();
    send_rsp(3'd5, 1'b0, w);
    total++;
    if (valid_o !== '0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL illegal_head got=v%b e%b exp=v0000 e0", valid_o, err_o);
    end
    tick();
    total++;
    if (err_o !== 1'b1 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL illegal_err got=e%b rdy%b exp=e1 rdy1", err_o, ready_o);
    end
    repeat (5) tick();
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL illegal_sticky got=%b exp=1", err_o);
    end
    do_reset();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL illegal_clear got=%b exp=0", err_o);
    end
  endtask

  task automatic test_saturate();
    int w;
    do_reset();
    ready_i = 4'b0111;
    repeat (MAXO) pulse_sent(4'b1000);
    total++;
    if (allow_o !== 4'b0111 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL sat_allow got=a%b e%b exp=a0111 e0", allow_o, err_o);
    end
    send_rsp(3'd3, 1'b1, w);
    total++;
    if (valid_o !== 4'b1000) begin
      bad++;
      $display("FAIL sat_head got=%b exp=1000", valid_o);
    end
    ready_i = '1;
    sent_i  = 4'b1000;
    tick();
    sent_i  = '0;
    total++;
    if (allow_o !== 4'b0111 || err_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL sat_same_cycle got=a%b e%b q%0d exp=a0111 e0 q0", allow_o, err_o, exp_q.size());
    end
    // Still at the limit: one more send overflows.
    pulse_sent(4'b1000);
    total++;
    if (allow_o !== 4'b0111 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL sat_overflow got=a%b e%b exp=a0111 e1", allow_o, err_o);
    end
  endtask

  task automatic test_reset_mid();
    int w, base;
    do_reset();
    ready_i = 4'b1101;
    repeat (2) pulse_sent(4'b0010);
    send_rsp(3'd1, 1'b1, w);
    send_rsp(3'd1, 1'b1, w);
    total++;
    if (exp_q.size() != 2 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_buffered got=q%0d rdy%b exp=q2 rdy0", exp_q.size(), ready_o);
    end
    do_reset();
    total++;
    if (allow_o !== 4'hF || valid_o !== '0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_state got=a%b v%b rdy%b exp=a1111 v0000 rdy1", allow_o, valid_o, ready_o);
    end
    base = deliv_cnt;
    repeat (4) tick();
    total++;
    if (deliv_cnt != base || valid_o !== '0) begin
      bad++;
      $display("FAIL rmid_discard got=d%0d v%b exp=d0 v0000", deliv_cnt - base, valid_o);
    end
    send_rsp(3'd1, 1'b0, w);
    tick();
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_cnt_zero got=%b exp=1", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal_pid();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpdcache_l15_resp_demux.md
HPDCACHE_L15_RESP_DEMUX -- requirements
Module: hpdcache_l15_resp_demux

Interface
REQ-001 The block SHALL have parameter N, default 1, meaning the number of requester ports.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the per-port outstanding-request limit (>=1).
REQ-003 The block SHALL have parameter type hpdcache_mem_resp_t, default logic, meaning the response payload.
REQ-004 The block SHALL have parameter type req_portid_t, default logic, meaning the port-id field carried with the response.
REQ-005 clk_i  in  1  single clock; all logic rising-edge.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 mem_resp_valid_i  in  1  response from the L1.5 valid.
REQ-008 mem_resp_ready_o  out  1  block accepts the response.
REQ-009 mem_resp_pid_i  in  $bits(req_portid_t)  destination port of the response.
REQ-010 mem_resp_i  in  $bits(hpdcache_mem_resp_t)  response payload.
REQ-011 mem_resp_valid_o  out  [N-1:0] array of 1  per-port response valid.
REQ-012 mem_resp_ready_i  in  [N-1:0] array of 1  per-port response ready.
REQ-013 mem_resp_o  out  [N-1:0] array of hpdcache_mem_resp_t  per-port payload (same value broadcast to all ports).
REQ-014 mem_req_sent_i  in  [N-1:0] array of 1  pulse: port's request accepted downstream (the arbiter's ready AND valid).
REQ-015 mem_req_allow_o  out  [N-1:0] array of 1  port may issue another request.
REQ-016 err_pid_o  out  1  sticky: response with pid >= N, or with pid naming a port that has zero outstanding requests.

Function
REQ-017 Input responses SHALL enter a 2-entry FIFO (pid + payload); mem_resp_ready_o = FIFO not full; a push occurs on valid_i & ready_o.
REQ-018 Latency SHALL be exactly 1 cycle: a response pushed in cycle t appears at the FIFO head in cycle t+1 at the earliest; full throughput of 1 response/cycle SHALL be sustained when the destination port is always ready.
REQ-019 For head pid p < N with outstanding[p] > 0, mem_resp_valid_o[p] = 1 and all other valid_o = 0; the pop occurs on mem_resp_ready_i[p].
REQ-020 For a head pid that is illegal (pid >= N, or outstanding[pid] == 0), the head SHALL be popped in that cycle with no valid_o asserted, and err_pid_o SHALL be set from the next cycle.
REQ-021 Head-of-line order SHALL be strict; a stalled port blocks all subsequent responses.
REQ-022 Each port SHALL have a counter outstanding[i] of width $clog2(MAX_OUTSTANDING+1): +1 on mem_req_sent_i[i], -1 on a delivered pop to port i, unchanged when both events occur in the same cycle.
REQ-023 mem_req_allow_o[i] = (outstanding[i] < MAX_OUTSTANDING); mem_req_sent_i[i] while outstanding == MAX_OUTSTANDING SHALL saturate the counter and set err_pid_o.
REQ-024 A simultaneous push and pop on a full FIFO SHALL be forbidden (ready_o=0 when full); on a non-full, non-empty FIFO, a simultaneous push and pop SHALL leave the count unchanged.
REQ-025 mem_resp_o SHALL equal the FIFO head payload whenever the FIFO is non-empty; its value is don't-care when empty.

Reset
REQ-026 On rst_ni=0 at a clock edge: FIFO empty, all counters 0, err_pid_o=0, mem_resp_valid_o all 0, mem_resp_ready_o=1 from the first cycle after release, and mem_req_allow_o all 1.
REQ-027 A reset asserted mid-operation SHALL discard buffered responses without delivering them.

Structure
REQ-028 hpdcache_mem_resp_t and req_portid_t SHALL come from hpdcache_pkg; no new package types are required.
REQ-029 The 2-entry FIFO SHALL be one sub-module, hpdcache_fifo_reg, with DEPTH=2.

Verification
REQ-030 N=4: send req to port 2, then a response with pid=2 -> valid_o[2] one cycle later, outstanding[2] returns to 0, err_pid_o=0.
REQ-031 N=4: back-to-back responses to pids 0,1,0 with all ports ready -> one delivery per cycle in order, mem_resp_ready_o never deasserts.
REQ-032 Port 1 ready=0 with 3 responses queued to pid 1 -> FIFO fills after 2, mem_resp_ready_o=0, and the third response is held upstream until ready_i[1]=1.
REQ-033 Response with pid=5 (N=4) -> dropped within 1 cycle, no valid_o asserted, err_pid_o=1 and it stays set until reset.
REQ-034 MAX_OUTSTANDING=4: 4 sent pulses on port 3 -> allow_o[3]=0; a response delivered to port 3 in the same cycle as a new sent pulse -> counter stays at 4.
REQ-035 Reset asserted with 2 responses buffered -> after release, no valid_o asserted, counters 0, allow_o all 1.
